host_mmio_responder: RTL and testbench

//  Responder on the CPU data port (load/store/address/store_data -> load_data) for the host-control window.

---
 rtl/host_mmio_responder.sv | 205 ++++++++++++++++++++
 tb/tb_host_mmio_responder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : host_mmio_responder
// Purpose  : Host-control MMIO window (HALT, SIG_BEGIN, SIG_END, CONSOLE,
//            STATUS) on the CPU data port, with a console byte FIFO that is
//            drained before halt is reported.
// Options  : HOST_CONSOLE_EN - console FIFO, con_* port, DRAIN state and
//            STATUS fields; without it STATUS reads "empty" only.
// Revision : 1.0 - initial release
// ============================================================================
module host_mmio_responder #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BASE       = 'h2000_0000,
    parameter int              FIFO_DEPTH = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            sel,
    output logic [7:0]      con_data,
    output logic            con_valid,
    input  logic            con_ready,
    output logic            halted,
    output logic [30:0]     exit_code,
    output logic [XLEN-1:0] sig_begin,
    output logic [XLEN-1:0] sig_end
);

    localparam int         c_W        = XLEN / 8;
    localparam logic [5:0] c_OFF_HALT = 6'd0;
    localparam logic [5:0] c_OFF_SIGB = 6'(c_W);
    localparam logic [5:0] c_OFF_SIGE = 6'(2 * c_W);
    localparam logic [5:0] c_OFF_CON  = 6'(3 * c_W);
    localparam logic [5:0] c_OFF_STAT = 6'(4 * c_W);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_halted;
    logic [30:0]     r_exit;
    logic [XLEN-1:0] r_sigb;
    logic [XLEN-1:0] r_sige;

    logic [5:0]      w_off;
    logic            w_wr;
    logic            w_wr_halt;
    logic            w_wr_sigb;
    logic            w_wr_sige;
    logic            w_empty_next;
    logic [XLEN-1:0] w_status;

    assign w_off     = address[5:0];
    assign sel       = (address[XLEN-1:6] == BASE[XLEN-1:6]);
    assign w_wr      = store & sel;
    assign w_wr_halt = w_wr & (w_off == c_OFF_HALT);
    assign w_wr_sigb = w_wr & (w_off == c_OFF_SIGB);
    assign w_wr_sige = w_wr & (w_off == c_OFF_SIGE);

`ifdef HOST_CONSOLE_EN
    localparam int              c_AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_AW:0]   c_ONE_CNT  = (c_AW + 1)'(1);

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_ovf;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push_req;
    logic            w_push;
    logic            w_ovf_set;
    logic            w_wr_stat;
    logic [7:0]      w_cnt8;

    assign w_full     = (r_count == c_FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = ~w_empty & con_ready;
    assign w_wr_stat  = w_wr & (w_off == c_OFF_STAT);
    assign w_push_req = w_wr & (w_off == c_OFF_CON) & (r_state == S_RUN);
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & ~w_push;
    // A push never coincides with a HALT write, so only a pop can empty it.
    assign w_empty_next = w_empty | ((r_count == c_ONE_CNT) & w_pop);

    assign w_cnt8    = 8'(r_count);
    assign w_status  = XLEN'({w_cnt8, 5'b0, r_ovf, w_empty, w_full});
    assign con_valid = ~w_empty;
    assign con_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE_CNT;
                2'b01:   r_count <= r_count - c_ONE_CNT;
                default: r_count <= r_count;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat & store_data[2]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= store_data[7:0];
        end
    end
`else
    logic w_unused_con_ready;

    assign w_unused_con_ready = con_ready;
    assign w_empty_next       = 1'b1;
    assign w_status           = XLEN'(32'h2);
    assign con_valid          = 1'b0;
    assign con_data           = 8'h00;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
            r_exit   <= '0;
            r_sigb   <= '0;
            r_sige   <= '0;
        end else begin
            if (w_wr_sigb && (r_state != S_HALTED)) begin
                r_sigb <= store_data;
            end
            if (w_wr_sige && (r_state != S_HALTED)) begin
                r_sige <= store_data;
            end
            case (r_state)
                S_RUN: begin
                    if (w_wr_halt && store_data[0]) begin
                        r_exit <= store_data[31:1];
                        if (w_empty_next) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state  <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_empty_next) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                S_HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    always_comb begin
        load_data = '0;
        if (load && sel) begin
            case (w_off)
                c_OFF_HALT: load_data = XLEN'({r_exit, r_halted});
                c_OFF_SIGB: load_data = r_sigb;
                c_OFF_SIGE: load_data = r_sige;
                c_OFF_STAT: load_data = w_status;
                default:    load_data = '0;
            endcase
        end
    end

    assign halted    = r_halted;
    assign exit_code = r_exit;
    assign sig_begin = r_sigb;
    assign sig_end   = r_sige;

endmodule
`default_nettype wire

// File: tb/tb_host_mmio_responder.sv
`default_nettype none
// Testbench for host_mmio_responder: directed scenarios plus randomized
// traffic checked against a queue-based model of the host window.
module tb_host_mmio_responder;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          DEPTH = 16;
`ifdef HOST_CONSOLE_EN
    localparam bit CON_EN = 1'b1;
`else
    localparam bit CON_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        con_ready = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] store_data = '0;
    logic [31:0] load_data;
    logic        sel;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        halted;
    logic [30:0] exit_code;
    logic [31:0] sig_begin;
    logic [31:0] sig_end;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the window
    logic [7:0]  m_q[$];
    bit          m_ovf;
    bit          m_halted;
    bit          m_drain;
    logic [30:0] m_exit;
    logic [31:0] m_sigb;
    logic [31:0] m_sige;

    host_mmio_responder #(
        .XLEN       (32),
        .BASE       (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .store      (store),
        .address    (address),
        .store_data (store_data),
        .load_data  (load_data),
        .sel        (sel),
        .con_data   (con_data),
        .con_valid  (con_valid),
        .con_ready  (con_ready),
        .halted     (halted),
        .exit_code  (exit_code),
        .sig_begin  (sig_begin),
        .sig_end    (sig_end)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_q.delete();
        m_ovf    = 1'b0;
        m_halted = 1'b0;
        m_drain  = 1'b0;
        m_exit   = '0;
        m_sigb   = '0;
        m_sige   = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit         wr;
        bit         run;
        bit         pop;
        bit         ovf_set;
        int         sz;
        logic [5:0] off;
        wr      = store && (address[31:6] == BASE[31:6]);
        off     = address[5:0];
        run     = !m_halted && !m_drain;
        pop     = 1'b0;
        ovf_set = 1'b0;
        sz      = m_q.size();
`ifdef HOST_CONSOLE_EN
        pop = (sz != 0) && con_ready;
        if (pop) void'(m_q.pop_front());
        if (wr && off == 6'd12 && run) begin
            if (sz < DEPTH || pop) m_q.push_back(store_data[7:0]);
            else ovf_set = 1'b1;
        end
        if (wr && off == 6'd16 && store_data[2]) m_ovf = 1'b0;
        if (ovf_set) m_ovf = 1'b1;
`endif
        if (wr && !m_halted && off == 6'd4) m_sigb = store_data;
        if (wr && !m_halted && off == 6'd8) m_sige = store_data;
        if (run && wr && off == 6'd0 && store_data[0]) begin
            m_exit = store_data[31:1];
            if (m_q.size() == 0) m_halted = 1'b1;
            else m_drain = 1'b1;
        end else if (m_drain && m_q.size() == 0) begin
            m_drain  = 1'b0;
            m_halted = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_read();
        if (!(load && address[31:6] == BASE[31:6])) return 32'h0;
        case (address[5:0])
            6'd0:  return {m_exit, m_halted};
            6'd4:  return m_sigb;
            6'd8:  return m_sige;
`ifdef HOST_CONSOLE_EN
            6'd16: return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH)};
`else
            6'd16: return 32'h2;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; load = 1'b0; store = 1'b0; con_ready = 1'b0;
        address = '0; store_data = '0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        load = 1'b0; store = 1'b1; address = a; store_data = d;
        tick();
        store = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({con_valid, halted, exit_code, sig_begin, sig_end, con_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b halted=%b exit=%h sb=%h se=%h data=%h expected all 0",
                     con_valid, halted, exit_code, sig_begin, sig_end, con_data);
        end
        load = 1'b1; address = BASE + 32'h10; #1;
        n_checks++;
        if (load_data !== 32'h2) begin
            n_fail++; $display("FAIL reset_status: got %h expected %h", load_data, 32'h2);
        end
        load = 1'b0;
    endtask

    task automatic test_console_stream();
        apply_reset();
        con_ready = 1'b1;
        load = 1'b0; store = 1'b1; address = BASE + 32'hC; store_data = 32'h41; #1;
        n_checks++;
        if (con_valid !== 1'b0) begin
            n_fail++; $display("FAIL con_no_bypass: valid=%b expected 0", con_valid);
        end
        tick();
        n_checks++;
        if (con_valid !== CON_EN || con_data !== (CON_EN ? 8'h41 : 8'h00)) begin
            n_fail++; $display("FAIL con_first: valid=%b data=%h expected valid=%b data=41", con_valid, con_data, CON_EN);
        end
        do_store(BASE + 32'hC, 32'h42);
        n_checks++;
        if (con_valid !== CON_EN || con_data !== (CON_EN ? 8'h42 : 8'h00)) begin
            n_fail++; $display("FAIL con_second: valid=%b data=%h expected valid=%b data=42", con_valid, con_data, CON_EN);
        end
        tick();
        n_checks++;
        if (con_valid !== 1'b0) begin
            n_fail++; $display("FAIL con_empty_end: valid=%b expected 0", con_valid);
        end
    endtask

    task automatic test_halt_drain();
        apply_reset();
        con_ready = 1'b0;
        do_store(BASE + 32'hC, 32'h43);
        do_store(BASE, 32'h5);
        n_checks++;
        if (halted !== !CON_EN) begin
            n_fail++; $display("FAIL halt_drain_wait: halted=%b expected %b", halted, !CON_EN);
        end
        con_ready = 1'b1;
        n_checks++;
        if (con_data !== (CON_EN ? 8'h43 : 8'h00)) begin
            n_fail++; $display("FAIL halt_drain_head: data=%h expected 43", con_data);
        end
        tick();
        n_checks++;
        if (halted !== 1'b1 || exit_code !== 31'd2 || con_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_done: halted=%b exit=%h valid=%b expected 1/2/0", halted, exit_code, con_valid);
        end
        do_store(BASE, 32'h9);
        n_checks++;
        if (exit_code !== 31'd2 || halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_sticky: exit=%h halted=%b expected 2/1", exit_code, halted);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        con_ready = 1'b0;
        for (int i = 0; i < 17; i++) do_store(BASE + 32'hC, 32'(i));
        load = 1'b1; address = BASE + 32'h10; #1;
        n_checks++;
        if (load_data !== (CON_EN ? 32'h1005 : 32'h2)) begin
            n_fail++; $display("FAIL ovf_status: got %h expected %h", load_data, CON_EN ? 32'h1005 : 32'h2);
        end
        load = 1'b0;
        con_ready = 1'b1;
`ifdef HOST_CONSOLE_EN
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (con_valid !== 1'b1 || con_data !== 8'(i)) begin
                n_fail++; $display("FAIL ovf_drain_%0d: valid=%b data=%h expected 1/%h", i, con_valid, con_data, 8'(i));
            end
            tick();
        end
`endif
        n_checks++;
        if (con_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drained: valid=%b expected 0", con_valid);
        end
        do_store(BASE + 32'h10, 32'h4);
        load = 1'b1; address = BASE + 32'h10; #1;
        n_checks++;
        if (load_data !== 32'h2) begin
            n_fail++; $display("FAIL ovf_clear: got %h expected 00000002", load_data);
        end
        load = 1'b0;
    endtask

    task automatic test_sig();
        apply_reset();
        do_store(BASE + 32'h4, 32'h8000_1000);
        do_store(BASE + 32'h8, 32'h8000_2000);
        n_checks++;
        if (sig_begin !== 32'h8000_1000 || sig_end !== 32'h8000_2000) begin
            n_fail++; $display("FAIL sig_regs: sb=%h se=%h expected 80001000/80002000", sig_begin, sig_end);
        end
        load = 1'b1; address = BASE + 32'h4; #1;
        n_checks++;
        if (load_data !== 32'h8000_1000) begin
            n_fail++; $display("FAIL sig_begin_read: got %h expected 80001000", load_data);
        end
        address = BASE + 32'h8; #1;
        n_checks++;
        if (load_data !== 32'h8000_2000) begin
            n_fail++; $display("FAIL sig_end_read: got %h expected 80002000", load_data);
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        con_ready = 1'b0;
        do_store(BASE + 32'h4, 32'hCAFE_0001);
        for (int i = 0; i < 5; i++) do_store(BASE + 32'hC, 32'h60 + 32'(i));
        do_store(BASE, 32'h7);
        n_checks++;
        if (halted !== m_halted || con_valid !== (m_q.size() != 0)) begin
            n_fail++; $display("FAIL drain_pre_reset: halted=%b valid=%b expected %b/%b", halted, con_valid, m_halted, m_q.size() != 0);
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({con_valid, halted, exit_code, sig_begin, sig_end, con_data, load_data} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b halted=%b exit=%h sb=%h data=%h ld=%h expected all 0",
                     con_valid, halted, exit_code, sig_begin, con_data, load_data);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        load = 1'b1; address = BASE + 32'h10; #1;
        n_checks++;
        if (load_data !== 32'h2) begin
            n_fail++; $display("FAIL reset_release_status: got %h expected 00000002", load_data);
        end
        load = 1'b0;
    endtask

    task automatic test_outside_window();
        apply_reset();
        store = 1'b1; address = 32'h8000_0000; store_data = 32'h1; #1;
        n_checks++;
        if (sel !== 1'b0) begin
            n_fail++; $display("FAIL outside_sel: sel=%b expected 0", sel);
        end
        tick();
        store = 1'b0;
        n_checks++;
        if (halted !== 1'b0 || exit_code !== '0) begin
            n_fail++; $display("FAIL outside_no_effect: halted=%b exit=%h expected 0/0", halted, exit_code);
        end
        load = 1'b1; address = BASE + 32'h3C; #1;
        n_checks++;
        if (sel !== 1'b1 || load_data !== 32'h0) begin
            n_fail++; $display("FAIL unused_offset_read: sel=%b data=%h expected 1/0", sel, load_data);
        end
        load = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_ld;
        logic [7:0]  exp_cd;
        for (int c = 0; c < 400; c++) begin
            if (c % 100 == 0) apply_reset();
            case ($urandom_range(0, 7))
                0: address = BASE;
                1: address = BASE + 32'h4;
                2: address = BASE + 32'h8;
                3, 4: address = BASE + 32'hC;
                5: address = BASE + 32'h10;
                6: address = BASE + 32'h3C;
                default: address = 32'h4000_0000 | ($urandom() & 32'hFFC);
            endcase
            store      = ($urandom_range(0, 9) < 5);
            load       = ~store | ($urandom_range(0, 1) == 1);
            con_ready  = ($urandom_range(0, 3) == 0);
            store_data = $urandom();
            if (address == BASE) store_data[0] = ($urandom_range(0, 11) == 0);
            #1;
            exp_ld = model_read();
            exp_cd = (m_q.size() != 0) ? m_q[0] : 8'h00;
            n_checks++;
            if (sel !== (address[31:6] == BASE[31:6]) || load_data !== exp_ld ||
                con_valid !== (m_q.size() != 0) || con_data !== exp_cd) begin
                n_fail++;
                $display("FAIL rand_comb c=%0d: sel=%b ld=%h valid=%b data=%h expected ld=%h valid=%b data=%h",
                         c, sel, load_data, con_valid, con_data, exp_ld, m_q.size() != 0, exp_cd);
            end
            tick();
            n_checks++;
            if (halted !== m_halted || exit_code !== m_exit || sig_begin !== m_sigb || sig_end !== m_sige) begin
                n_fail++;
                $display("FAIL rand_state c=%0d: halted=%b exit=%h sb=%h se=%h expected %b/%h/%h/%h",
                         c, halted, exit_code, sig_begin, sig_end, m_halted, m_exit, m_sigb, m_sige);
            end
        end
        store = 1'b0; load = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_console_stream();
        test_halt_drain();
        test_overflow();
        test_sig();
        test_reset_mid_drain();
        test_outside_window();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
